// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: sequencer state type and address-width helper for mem_bank
package mem_bank_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic int addr_w(input int depth);
    return depth > 2 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mem_bank.sv
// mem_bank: WIDTH x DEPTH bank, clock/reset, clear->busy zeroing sequence, wr_en/wr_addr/wr_data write port, rd_en/rd_addr -> rd_data/rd_valid registered read with bypass
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy
);
  localparam logic [ADDR_W:0] SIZE = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic idle, wr_ok, rd_ok, rd_in;
  always_comb begin
    idle = state == IDLE && !clear;
    wr_ok = idle && wr_en && {1'b0, wr_addr} < SIZE;
    rd_ok = idle && rd_en;
    rd_in = {1'b0, rd_addr} < SIZE;
    state_nx = state == CLEAR ? (clr_ptr == LAST ? IDLE : CLEAR) : (clear ? CLEAR : IDLE);
  end
  always_ff @(posedge clock) begin
    state <= reset ? CLEAR : state_nx;
    clr_ptr <= !reset && state == CLEAR ? clr_ptr + 1'b1 : '0;
    rd_valid <= !reset && rd_ok;
    rd_data <= reset ? '0 : rd_ok ? (rd_in ? (wr_ok && wr_addr == rd_addr ? wr_data : mem[rd_addr]) : '0) : rd_data;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_ok) mem[wr_addr] <= wr_data;
    end
  assign busy = state == CLEAR;
endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: scoreboard bench for an 8x4 and a 12x5 mem_bank instance
module tb_mem_bank;
  logic clock = 0;
  always #5 clock = ~clock;
  int n_cmp = 0, n_err = 0;
  logic a_reset = 1, a_clear = 0, a_wr_en = 0, a_rd_en = 0;
  logic [1:0] a_wr_addr = 0, a_rd_addr = 0;
  logic [7:0] a_wr_data = 0, a_rd_data;
  logic a_rd_valid, a_busy;
  logic b_reset = 1, b_clear = 0, b_wr_en = 0, b_rd_en = 0;
  logic [2:0] b_wr_addr = 0, b_rd_addr = 0;
  logic [11:0] b_wr_data = 0, b_rd_data;
  logic b_rd_valid, b_busy;
  logic [7:0] mdl_a [0:3];
  logic [11:0] mdl_b [0:4];
  logic [31:0] qa[$], qb[$];
  mem_bank #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clock(clock), .reset(a_reset), .clear(a_clear), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .busy(a_busy)
  );
  mem_bank #(.WIDTH(12), .DEPTH(5)) dut_b (
    .clock(clock), .reset(b_reset), .clear(b_clear), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .busy(b_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    if (a_rd_valid) begin
      if (qa.size() == 0) check("a_spurious_valid", 1, 0);
      else check("a_rd_data", {24'h0, a_rd_data}, qa.pop_front());
    end
    if (b_rd_valid) begin
      if (qb.size() == 0) check("b_spurious_valid", 1, 0);
      else check("b_rd_data", {20'h0, b_rd_data}, qb.pop_front());
    end
  end
  task automatic op_a(input logic c, we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic re, input logic [1:0] ra, input bit idle);
    a_clear = c; a_wr_en = we; a_wr_addr = wa; a_wr_data = wd; a_rd_en = re; a_rd_addr = ra;
    if (idle && c) for (int i = 0; i < 4; i++) mdl_a[i] = 0;
    else if (idle) begin
      if (re) qa.push_back({24'h0, (we && wa == ra) ? wd : mdl_a[ra]});
      if (we) mdl_a[wa] = wd;
    end
    @(posedge clock); #1;
    a_clear = 0; a_wr_en = 0; a_rd_en = 0;
  endtask
  task automatic op_b(input logic we, input logic [2:0] wa, input logic [11:0] wd,
                      input logic re, input logic [2:0] ra);
    b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_rd_en = re; b_rd_addr = ra;
    if (re) qb.push_back({20'h0, ra > 4 ? 12'h0 : (we && wa == ra) ? wd : mdl_b[ra]});
    if (we && wa < 5) mdl_b[wa] = wd;
    @(posedge clock); #1;
    b_wr_en = 0; b_rd_en = 0;
  endtask
  task automatic busy_len_a(input string tag, input int exp);
    int n = 0;
    while (a_busy && n < 100) begin n++; @(posedge clock); #1; end
    check(tag, n, exp);
  endtask
  task automatic reset_a();
    a_reset = 1;
    repeat (2) @(posedge clock);
    #1;
    check("a_rst_busy", {31'h0, a_busy}, 1);
    check("a_rst_valid", {31'h0, a_rd_valid}, 0);
    check("a_rst_data", {24'h0, a_rd_data}, 0);
    for (int i = 0; i < 4; i++) mdl_a[i] = 0;
    a_reset = 0;
  endtask
  task automatic read_all_a();
    for (int i = 0; i < 4; i++) op_a(0, 0, 0, 0, 1, 2'(i), 1);
    op_a(0, 0, 0, 0, 0, 0, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    reset_a();
    busy_len_a("a_busy_after_reset", 4);
    read_all_a();
    op_a(0, 1, 1, 8'hA5, 0, 0, 1);
    op_a(0, 1, 2, 8'h3C, 0, 0, 1);
    op_a(0, 0, 0, 0, 1, 1, 1);
    op_a(0, 0, 0, 0, 1, 2, 1);
    op_a(0, 1, 3, 8'h11, 0, 0, 1);
    op_a(0, 1, 3, 8'h77, 1, 3, 1);
    op_a(0, 0, 0, 0, 1, 3, 1);
    op_a(0, 1, 0, 8'h5A, 0, 0, 1);
    op_a(0, 0, 0, 0, 1, 0, 1);
    op_a(0, 0, 0, 0, 0, 0, 1);
    op_a(1, 1, 0, 8'hFF, 1, 0, 1);
    check("a_busy_on_clear", {31'h0, a_busy}, 1);
    op_a(0, 1, 1, 8'hEE, 1, 1, 0);
    busy_len_a("a_busy_rest_of_clear", 3);
    read_all_a();
    op_a(0, 1, 2, 8'h99, 0, 0, 1);
    op_a(0, 0, 0, 0, 0, 0, 1);
    a_reset = 1;
    @(posedge clock); #1;
    a_reset = 0;
    for (int i = 0; i < 4; i++) mdl_a[i] = 0;
    @(posedge clock); #1;
    check("a_busy_mid", {31'h0, a_busy}, 1);
    a_reset = 1;
    @(posedge clock); #1;
    a_reset = 0;
    busy_len_a("a_busy_after_mid_reset", 4);
    read_all_a();
    b_reset = 1;
    repeat (2) @(posedge clock);
    #1;
    check("b_rst_busy", {31'h0, b_busy}, 1);
    b_reset = 0;
    for (int i = 0; i < 5; i++) mdl_b[i] = 0;
    begin
      int n = 0;
      while (b_busy && n < 100) begin n++; @(posedge clock); #1; end
      check("b_busy_after_reset", n, 5);
    end
    op_b(1, 4, 12'hABC, 0, 0);
    op_b(1, 6, 12'h123, 0, 0);
    op_b(0, 0, 0, 1, 4);
    op_b(0, 0, 0, 1, 6);
    op_b(0, 0, 0, 1, 7);
    op_b(0, 0, 0, 1, 0);
    op_b(0, 0, 0, 0, 0);
    op_b(0, 0, 0, 0, 0);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
